// File: rtl/sorted_stream_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : sorted_stream_tx_if
//  Description : 4-bit element stream with valid/ready handshake and a
//                last-beat marker, carried from sorted_stream_tx downstream.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sorted_stream_tx_if;
    logic [3:0] data;
    logic       valid;
    logic       last;
    logic       ready;

    // Producer side drives the beat, consumer side drives ready.
    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);
endinterface
`default_nettype wire

// File: rtl/sorted_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : sorted_stream_tx
//  Description : Captures the sorter's 8x4-bit result word on the rising edge
//                of its valid level, re-checks non-decreasing order, then
//                streams the 8 elements out one per handshake beat.
//  Revision    : 1.0 - initial release
// ============================================================================
module sorted_stream_tx (
    input  wire logic        clk_i,
    input  wire logic        rst_i,
    input  wire logic        valid_i,
    input  wire logic [31:0] nums_i,
    sorted_stream_tx_if.master tx,
    output logic             sorted_err_o,
    output logic             done_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CHECK = 2'd1;
    localparam logic [1:0] c_SEND  = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_buf;
    logic [2:0]  r_idx;
    logic        r_valid_q;
    logic        r_err;

    logic        w_rise;
    logic [2:0]  w_idx_nxt;
    logic [3:0]  w_cur;
    logic [3:0]  w_nxt;
    logic        w_sending;
    logic        w_accept;

    // Element k lives at bits [4k+3:4k]; the neighbour index wraps harmlessly
    // at 7 because the comparison is only used while idx is 0..6.
    assign w_rise    = valid_i & ~r_valid_q;
    assign w_idx_nxt = r_idx + 3'd1;
    assign w_cur     = r_buf[{r_idx, 2'b00} +: 4];
    assign w_nxt     = r_buf[{w_idx_nxt, 2'b00} +: 4];
    assign w_sending = (r_state == c_SEND);
    assign w_accept  = w_sending & tx.ready;

    // Delayed copy of the sorter valid level, used for rising-edge detection.
    // It tracks in every state so edges arriving while busy are consumed.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_q <= 1'b0;
        end else begin
            r_valid_q <= valid_i;
        end
    end

    // Main control: capture, order check, streaming and re-arm.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
            r_buf   <= 32'd0;
            r_idx   <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_rise) begin
                        r_buf   <= nums_i;
                        r_idx   <= 3'd0;
                        r_err   <= 1'b0;
                        r_state <= c_CHECK;
                    end
                end
                c_CHECK: begin
                    if (w_cur > w_nxt) begin
                        r_err <= 1'b1;
                    end
                    if (r_idx == 3'd6) begin
                        r_idx   <= 3'd0;
                        r_state <= c_SEND;
                    end else begin
                        r_idx <= w_idx_nxt;
                    end
                end
                c_SEND: begin
                    if (w_accept) begin
                        if (r_idx == 3'd7) begin
                            r_state <= c_DONE;
                        end else begin
                            r_idx <= w_idx_nxt;
                        end
                    end
                end
                c_DONE: begin
                    if (!valid_i) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; data is forced to zero when no
    // beat is being offered.
    assign tx.valid     = w_sending;
    assign tx.data      = w_sending ? w_cur : 4'd0;
    assign tx.last      = w_sending && (r_idx == 3'd7);
    assign done_o       = (r_state == c_DONE);
    assign sorted_err_o = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sorted_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sorted_stream_tx
//  Description : Self-checking bench for sorted_stream_tx; directed scenarios
//                plus randomized words, stalls and valid_i disturbances.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sorted_stream_tx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [31:0] nums_i;
    logic        sorted_err_o;
    logic        done_o;

    int n_cmp = 0;
    int n_err = 0;

    sorted_stream_tx_if tx_if ();

    sorted_stream_tx dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .valid_i      (valid_i),
        .nums_i       (nums_i),
        .tx           (tx_if.master),
        .sorted_err_o (sorted_err_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: a word is in error if any element exceeds its successor.
    function automatic bit model_err(input logic [31:0] w);
        for (int k = 0; k < 7; k++) begin
            if (w[4*k +: 4] > w[4*k+4 +: 4]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_quiet(input string tag);
        check({tag, "_valid"}, tx_if.valid, 0);
        check({tag, "_data"},  tx_if.data,  0);
        check({tag, "_last"},  tx_if.last,  0);
        check({tag, "_done"},  done_o,      0);
        check({tag, "_err"},   sorted_err_o, 0);
    endtask

    task automatic capture(input logic [31:0] w);
        nums_i  = w;
        valid_i = 1'b1;
        tick();
        check("cap_valid", tx_if.valid, 0);
        check("cap_done",  done_o,      0);
    endtask

    // mode 0: valid held; 1: valid dropped mid-check; 2: dropped then raised.
    task automatic check_phase(input int mode);
        for (int i = 1; i <= 7; i++) begin
            nums_i = $urandom;
            if (mode != 0 && i == 3) valid_i = 1'b0;
            if (mode == 2 && i == 5) valid_i = 1'b1;
            tick();
            check("chk_valid", tx_if.valid, (i == 7) ? 1 : 0);
            check("chk_done",  done_o, 0);
        end
    endtask

    task automatic send_phase(input logic [31:0] w, input logic [7:0] stall_once,
                              input int stall_pct, input int abort_beat, output bit aborted);
        bit e;
        bit rdy;
        bit first;
        bit go;
        int waits;
        e       = model_err(w);
        aborted = 1'b0;
        for (int k = 0; k < 8; k++) begin
            waits = 0;
            first = 1'b1;
            go    = 1'b0;
            while (!go) begin
                if (first && stall_once[k]) rdy = 1'b0;
                else if (waits >= 20)       rdy = 1'b1;
                else rdy = ($urandom_range(0, 99) >= stall_pct);
                first = 1'b0;
                tx_if.ready = rdy;
                check("beat_valid", tx_if.valid, 1);
                check("beat_data",  tx_if.data,  w[4*k +: 4]);
                check("beat_last",  tx_if.last,  (k == 7) ? 1 : 0);
                check("beat_err",   sorted_err_o, e);
                check("beat_done",  done_o, 0);
                if (rdy && k == abort_beat) begin
                    rst_i = 1'b1;
                    tick();
                    rst_i       = 1'b0;
                    tx_if.ready = 1'b0;
                    aborted     = 1'b1;
                    return;
                end
                tick();
                waits++;
                go = rdy;
            end
        end
        tx_if.ready = 1'b0;
        check("end_done",  done_o,      1);
        check("end_valid", tx_if.valid, 0);
        check("end_err",   sorted_err_o, e);
    endtask

    // Hold in DONE while valid_i is high, then release for one low cycle.
    task automatic finish_done(input logic [31:0] w);
        if (valid_i) begin
            for (int i = 0; i < 3; i++) begin
                nums_i = $urandom;
                tick();
                check("hold_done",  done_o,      1);
                check("hold_valid", tx_if.valid, 0);
                check("hold_err",   sorted_err_o, model_err(w));
            end
            valid_i = 1'b0;
        end
        tick();
        check("rearm_done",  done_o,      0);
        check("rearm_valid", tx_if.valid, 0);
    endtask

    task automatic run(input logic [31:0] w, input logic [7:0] stall_once,
                       input int stall_pct, input int mode);
        bit ab;
        capture(w);
        check_phase(mode);
        send_phase(w, stall_once, stall_pct, -1, ab);
        finish_done(w);
    endtask

    initial begin
        bit          ab;
        int          q[$];
        logic [31:0] w;

        rst_i       = 1'b1;
        valid_i     = 1'b0;
        nums_i      = 32'd0;
        tx_if.ready = 1'b0;
        tick();
        tick();
        check_quiet("reset");
        rst_i = 1'b0;
        tick();
        check_quiet("idle");

        run(32'h8765_4321, 8'h00, 0, 0);
        run(32'hFFF0_0000, 8'h00, 0, 0);
        run(32'h1234_5678, 8'h00, 0, 0);
        run(32'h8765_4321, 8'b1000_1001, 0, 0);
        run(32'h0000_0001, 8'h00, 0, 0);

        // Reset on the accepted element-4 beat, valid_i left high.
        capture(32'h8765_4321);
        check_phase(0);
        send_phase(32'h8765_4321, 8'h00, 0, 4, ab);
        check("abort_taken", ab, 1);
        check_quiet("after_rst");
        capture(32'h9876_5320);
        check_phase(0);
        send_phase(32'h9876_5320, 8'h00, 20, -1, ab);
        finish_done(32'h9876_5320);

        for (int t = 0; t < 24; t++) begin
            q.delete();
            for (int k = 0; k < 8; k++) q.push_back(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 1) == 1) q.sort();
            w = 32'd0;
            for (int k = 0; k < 8; k++) w[4*k +: 4] = q[k][3:0];
            run(w, 8'($urandom), int'($urandom_range(0, 60)), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sorted_stream_tx.md
# sorted_stream_tx

Consumer for the sorter result word: captures the 8×4-bit `sorted_nums` word when the sorter asserts its valid level, re-checks ascending order nibble by nibble, and streams the 8 numbers out one per beat over a valid/ready handshake. It sits directly after the sorter and converts its parallel one-shot result into a 4-bit stream for display and UART logic. It flags any ordering violation.

## Interface
- No parameters. Fixed: 8 elements, 4 bits each, element k = bits [4k+3:4k].
- `clk_i`  in  1  system clock; all logic on posedge.
- `rst_i`  in  1  reset; synchronous and active-high.
- `valid_i`  in  1  sorter valid level; stays high until the sorter is reset.
- `nums_i`  in  32  sorted word from the sorter.
- `ready_i`  in  1  downstream ready.
- `data_o`  out  4  current stream element.
- `valid_o`  out  1  `data_o` valid.
- `last_o`  out  1  current beat is element 7.
- `sorted_err_o`  out  1  sticky flag: captured word not non-decreasing.
- `done_o`  out  1  all 8 beats accepted; held until re-arm.

## Operation
- Registers:
  - `buf[31:0]`
  - `idx[2:0]`
  - `valid_q`: `valid_i` delayed 1 cycle, always updated.
  - `err`
  - `state`
- States: IDLE, CHECK, SEND, DONE.
- IDLE:
  - On `valid_i & ~valid_q` (rising edge): `buf <= nums_i`, `idx <= 0`, `err <= 0`, go CHECK.
  - Otherwise hold.
- CHECK:
  - Each cycle, if `buf[idx] > buf[idx+1]` (unsigned 4-bit compare), set `err`.
  - When `idx == 6`: `idx <= 0`, go SEND.
  - Else `idx <= idx + 1`.
  - Always exactly 7 cycles.
- SEND:
  - `valid_o = 1`, `data_o = buf[idx]`, `last_o = (idx == 7)`.
  - On `valid_o & ready_i`: if `idx == 7` go DONE, else `idx <= idx + 1`.
  - With `ready_i` low, `data_o`, `idx` and `last_o` are held stable.
- DONE:
  - `done_o = 1`.
  - When `valid_i == 0`, go IDLE on the next edge; the block is re-armed for the next sorter run.
  - While `valid_i` stays high, remain in DONE. No re-capture, because no new rising edge occurs.
- `sorted_err_o = err`.
  - Meaningful from the first SEND cycle through DONE.
  - Reads 0 in CHECK until a violation is found.
- Outputs are decoded from registered state only. There is no combinational path from `valid_i` or `nums_i` to any output, and `ready_i` affects only next-state.
- Boundary rules:
  - **`valid_i` falls during CHECK or SEND:** ignored; the transfer completes. DONE then exits after 1 cycle.
  - **`valid_i` rising edge outside IDLE:** dropped. `valid_q` still tracks, so the edge is consumed.
  - **`rst_i` in any state:** immediate return to IDLE with all outputs at reset values. A partial stream is abandoned.
  - **`rst_i` and a `valid_i` rising edge in the same cycle:** reset wins. `valid_q` clears to 0, so a still-high `valid_i` is seen as a rising edge on the first cycle after reset.
  - **Equal adjacent elements:** not an error.

## Timing
- Reset values:
  - `data_o` = 0, `valid_o` = 0, `last_o` = 0, `sorted_err_o` = 0, `done_o` = 0.
  - Internal: `buf` = 0, `idx` = 0, `valid_q` = 0.
- Capture at edge E, i.e. the first edge where `valid_i` = 1 and `valid_q` = 0.
- CHECK occupies edges E+1..E+7.
- `valid_o` is high after edge E+7.
- With `ready_i` held high:
  - Beats k = 0..7 are accepted at edges E+8..E+15.
  - `last_o` is high only during the beat accepted at E+15.
  - `done_o` is high after edge E+15.
- Each low-`ready_i` cycle in SEND delays all later beats by one cycle.
- Minimum turnaround: `valid_i` low for 1 cycle in DONE, then high again, gives a new capture 2 edges later.

## Test plan
- **Basic stream:** reset, then `nums_i` = 0x8765_4321 (elements 1..8) with `valid_i` rising and `ready_i` = 1.
  - `data_o` sequence 1,2,…,8 on consecutive cycles starting after E+7.
  - `last_o` only on 8; `sorted_err_o` = 0; `done_o` after E+15.
- **Duplicates and extremes:** `nums_i` = 0xFFF0_0000 (0,0,0,0,0,F,F,F).
  - Stream is 0,0,0,0,0,F,F,F; `sorted_err_o` = 0.
- **Unsorted detection:** `nums_i` = 0x1234_5678 (8,7,…,1).
  - Stream is 8,7,…,1 unchanged; `sorted_err_o` = 1 from the first SEND cycle through DONE.
- **Backpressure:** basic stream with `ready_i` low on the cycles holding elements 0, 3 and 7.
  - `data_o` stable while stalled; no element lost or duplicated; `done_o` 3 cycles later than the no-stall case.
- **Re-arm:**
  - Keep `valid_i` high after DONE: `done_o` held, no second stream.
  - Drop `valid_i` for 1 cycle and raise it with `nums_i` = 0x0000_0001: new capture; stream 1,0,0,…; `sorted_err_o` = 1.
- **Mid-operation reset:** assert `rst_i` on the cycle the element-4 beat is accepted.
  - Next cycle all outputs are 0 and the state is IDLE.
  - With `valid_i` still high after `rst_i` drops, a fresh capture of the current `nums_i` starts.
